// File: rtl/picosoc_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : picosoc_mem_loader
// Brief    : Packs a little-endian byte stream into 32-bit words, writes them
//            to the picosoc SRAM port from a base word address, then reads the
//            region back and compares its checksum against the written data.
// Revision : 1.0 - initial release
// ============================================================================
module picosoc_mem_loader #(
  parameter int ADDR_WIDTH = 22,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  byte_count,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3:0]            mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           checksum
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [LEN_WIDTH-1:0]  r_nwords;
  logic [31:0]           r_lastmask;
  logic [LEN_WIDTH-1:0]  r_accepted;
  logic [1:0]            r_lane;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [31:0]           r_buf;
  logic [31:0]           r_wsum;
  logic [31:0]           r_rsum;
  logic [LEN_WIDTH-1:0]  r_rcyc;

  logic                  r_in_ready;
  logic [3:0]            r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [31:0]           r_checksum;

  logic                  w_accept;
  logic [LEN_WIDTH-1:0]  w_cnt_next;
  logic                  w_last_byte;
  logic [31:0]           w_buf_new;
  logic [3:0]            w_lane_mask;
  logic [LEN_WIDTH-1:0]  w_nwords;
  logic [31:0]           w_lastmask;
  logic [31:0]           w_rmask;
  logic [31:0]           w_rsum_next;
  logic [LEN_WIDTH-1:0]  w_rcyc_next;

  assign w_accept    = (r_state == S_LOAD) && in_valid && r_in_ready;
  assign w_cnt_next  = r_accepted + LEN_WIDTH'(1);
  assign w_last_byte = (w_cnt_next == r_count);
  assign w_buf_new   = r_buf | ({24'd0, in_data} << {r_lane, 3'b000});
  assign w_nwords    = (byte_count >> 2) + {{(LEN_WIDTH-1){1'b0}}, |byte_count[1:0]};
  assign w_rcyc_next = r_rcyc + LEN_WIDTH'(1);

  // Read data arriving in the last READ cycle belongs to the final word,
  // whose unwritten lanes must not contribute to the readback sum.
  assign w_rmask     = (r_rcyc == r_nwords) ? r_lastmask : 32'hFFFF_FFFF;
  assign w_rsum_next = r_rsum + (mem_rdata & w_rmask);

  // Lane fill masks: write-enable for the word being closed, and the data
  // mask for the final word of the transfer derived from the byte count.
  always_comb begin
    w_lane_mask = 4'b1111;
    w_lastmask  = 32'hFFFF_FFFF;
    case (r_lane)
      2'd0:    w_lane_mask = 4'b0001;
      2'd1:    w_lane_mask = 4'b0011;
      2'd2:    w_lane_mask = 4'b0111;
      default: w_lane_mask = 4'b1111;
    endcase
    case (byte_count[1:0])
      2'd1:    w_lastmask = 32'h0000_00FF;
      2'd2:    w_lastmask = 32'h0000_FFFF;
      2'd3:    w_lastmask = 32'h00FF_FFFF;
      default: w_lastmask = 32'hFFFF_FFFF;
    endcase
  end

  // Main controller: load/pack, single-cycle write, readback and verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_count    <= '0;
      r_nwords   <= '0;
      r_lastmask <= '0;
      r_accepted <= '0;
      r_lane     <= '0;
      r_word_idx <= '0;
      r_buf      <= '0;
      r_wsum     <= '0;
      r_rsum     <= '0;
      r_rcyc     <= '0;
      r_in_ready <= 1'b0;
      r_wen      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (byte_count == '0) begin
              // Empty transfer completes immediately without touching memory.
              r_done     <= 1'b1;
              r_checksum <= '0;
              r_error    <= 1'b0;
            end else begin
              r_base     <= base_addr;
              r_count    <= byte_count;
              r_nwords   <= w_nwords;
              r_lastmask <= w_lastmask;
              r_accepted <= '0;
              r_lane     <= '0;
              r_word_idx <= '0;
              r_buf      <= '0;
              r_wsum     <= '0;
              r_rsum     <= '0;
              r_checksum <= '0;
              r_error    <= 1'b0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_accepted <= w_cnt_next;
            r_lane     <= r_lane + 2'd1;
            r_buf      <= w_buf_new;
            if ((r_lane == 2'd3) || w_last_byte) begin
              r_wdata    <= w_buf_new;
              r_wen      <= w_lane_mask;
              r_addr     <= r_base + r_word_idx;
              r_in_ready <= 1'b0;
              r_state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_wen      <= 4'd0;
          r_wsum     <= r_wsum + r_wdata;
          r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
          r_buf      <= '0;
          if (r_accepted != r_count) begin
            r_in_ready <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_addr  <= r_base;
            r_rcyc  <= '0;
            r_rsum  <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // Address issued in cycle c returns data in cycle c+1.
          r_rcyc <= w_rcyc_next;
          if (r_rcyc != '0) begin
            r_rsum <= w_rsum_next;
          end
          if (w_rcyc_next < r_nwords) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
          if (r_rcyc == r_nwords) begin
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_checksum <= r_wsum;
            r_error    <= (w_rsum_next != r_wsum);
            r_state    <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_wen   = r_wen;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_picosoc_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_picosoc_mem_loader
// Brief    : Self-checking bench for picosoc_mem_loader with a behavioural SRAM
//            model, a word-packing reference model, table vectors and random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picosoc_mem_loader;

  localparam int AW = 22;
  localparam int LW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] byte_count;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [31:0]   checksum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  picosoc_mem_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  // Behavioural SRAM: byte-enabled write, one-cycle registered read, with an
  // optional single-word readback corruption.
  logic [31:0] mem [0:1023];
  bit          corrupt_en  = 1'b0;
  logic [9:0]  corrupt_idx = '0;

  always @(posedge clk) begin : p_mem
    logic [31:0] rd;
    rd = mem[mem_addr[9:0]];
    if (corrupt_en && (mem_addr[9:0] == corrupt_idx)) rd = rd ^ 32'h1;
    mem_rdata <= rd;
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) mem[mem_addr[9:0]][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    wen;
    logic [31:0]   data;
  } wr_t;

  wr_t wq[$];
  wr_t exp_q[$];
  bit  prev_wen   = 1'b0;
  int  wen_consec = 0;
  int  wen_idle   = 0;
  bit  busy_seen  = 1'b0;

  // Write monitor: records every write cycle and flags protocol breaches.
  always @(negedge clk) begin
    if (mem_wen != 4'd0) begin
      wq.push_back('{mem_addr, mem_wen, mem_wdata});
      if (prev_wen) wen_consec++;
      if (!busy) wen_idle++;
    end
    prev_wen = (mem_wen != 4'd0);
    if (busy) busy_seen = 1'b1;
  end

  logic [7:0] tx [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: byte k of the stream lands in lane k%4 of word k/4;
  // returns the sum of all written words.
  function automatic logic [31:0] model(input logic [AW-1:0] base, input int cnt);
    logic [31:0] sum;
    wr_t         w;
    int          nw;
    exp_q.delete();
    sum = 32'd0;
    nw  = (cnt + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w.addr = AW'(base + AW'(i));
      w.wen  = 4'd0;
      w.data = 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (4*i + k < cnt) begin
          w.wen[k]          = 1'b1;
          w.data[8*k +: 8]  = tx[4*i + k];
        end
      end
      exp_q.push_back(w);
      sum = sum + w.data;
    end
    return sum;
  endfunction

  // Runs one operation from start to the done pulse. Entered and left just
  // after a rising edge / at the done-cycle falling edge respectively.
  task automatic run_op(input logic [AW-1:0] base, input int cnt, input int gap,
                        input bit spam, output int lat);
    int idx;
    int n;
    int step;
    bit acc;
    wq.delete();
    busy_seen  = 1'b0;
    wen_consec = 0;
    wen_idle   = 0;
    lat        = -1;
    start      = 1'b1;
    base_addr  = base;
    byte_count = LW'(cnt);
    in_valid   = 1'b0;
    @(posedge clk);
    n = 1;
    #1;
    start    = 1'b0;
    idx      = 0;
    step     = 0;
    in_valid = (cnt > 0) && (gap != 1);
    in_data  = tx[0];
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      n++;
      #1;
      if (acc) idx++;
      step++;
      in_valid = (idx < cnt) && ((gap == 0) || (gap == 1 && (step % 2) == 0) ||
                                 (gap == 2 && $urandom_range(0, 2) != 0));
      in_data  = (idx < cnt) ? tx[idx] : 8'h00;
      start    = spam && busy;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout waiting for done actual=none required=pulse");
    end
  endtask

  typedef struct {
    int            cnt;
    logic [AW-1:0] base;
    int            gap;
    bit            corrupt;
    bit            preload;
    bit            spam;
    logic [31:0]   exp_sum;
    bit            exp_err;
  } vec_t;

  // Applies one vector: prepares memory, runs, and checks against the model.
  task automatic apply(input vec_t v);
    int          lat;
    int          nw;
    logic [31:0] msum;
    nw = (v.cnt + 3) / 4;
    if (v.preload) mem[10'(v.base + AW'(1))] = 32'hFFFF_FF00;
    corrupt_en  = v.corrupt;
    corrupt_idx = v.base[9:0];
    msum = model(v.base, v.cnt);
    run_op(v.base, v.cnt, v.gap, v.spam, lat);
    if (lat > 0) begin
      if (v.gap == 0)
        check("latency", 64'(lat), 64'((v.cnt == 0) ? 1 : 1 + v.cnt + nw + nw + 1));
      check("checksum", 64'(checksum), 64'(v.exp_sum));
      check("model_sum", 64'(checksum), 64'(msum));
      check("error", 64'(error), 64'(v.exp_err));
      check("busy_at_done", 64'(busy), 64'd0);
      check("num_writes", 64'(wq.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
        check("wr_addr", 64'(wq[i].addr), 64'(exp_q[i].addr));
        check("wr_wen", 64'(wq[i].wen), 64'(exp_q[i].wen));
        check("wr_data", 64'(wq[i].data), 64'(exp_q[i].data));
      end
      check("wen_back_to_back", 64'(wen_consec), 64'd0);
      check("wen_while_idle", 64'(wen_idle), 64'd0);
      if (v.cnt == 0) check("busy_seen_empty", 64'(busy_seen), 64'd0);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("error_held", 64'(error), 64'(v.exp_err));
      check("checksum_held", 64'(checksum), 64'(v.exp_sum));
    end
    corrupt_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"}, 64'(mem_wen), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_checksum"}, 64'(checksum), 64'd0);
  endtask

  vec_t tbl [0:5];
  vec_t rv;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 64; i++) tx[i] = 8'(i + 1);
    rst = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
    in_data = 8'h00; in_valid = 1'b0;

    tbl[0] = '{8, 22'h010, 0, 1'b0, 1'b0, 1'b0, 32'h0C0A_0806, 1'b0};
    tbl[1] = '{5, 22'h010, 0, 1'b0, 1'b1, 1'b0, 32'h0403_0206, 1'b0};
    tbl[2] = '{8, 22'h010, 0, 1'b1, 1'b0, 1'b0, 32'h0C0A_0806, 1'b1};
    tbl[3] = '{8, 22'h010, 1, 1'b0, 1'b0, 1'b1, 32'h0C0A_0806, 1'b0};
    tbl[4] = '{0, 22'h010, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    tbl[5] = '{8, 22'h3FFFFF, 0, 1'b0, 1'b0, 1'b0, 32'h0C0A_0806, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) apply(tbl[i]);

    // Reset mid-load, the cycle after the third byte is accepted.
    begin : b_mid_reset
      int  idx;
      bit  acc;
      wq.delete();
      start = 1'b1; base_addr = 22'h020; byte_count = LW'(8);
      @(posedge clk);
      #1;
      start = 1'b0; in_valid = 1'b1; idx = 0; in_data = tx[0];
      for (int k = 0; k < 50 && idx < 3; k++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) idx++;
        in_data = tx[idx];
      end
      check("bytes_before_reset", 64'(idx), 64'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      check("midrst_no_write", 64'(wq.size()), 64'd0);
      @(posedge clk);
      #1;
    end
    apply(tbl[0]);

    // Randomised operations against the reference model.
    for (int r = 0; r < 20; r++) begin
      rv.cnt  = $urandom_range(1, 40);
      for (int i = 0; i < rv.cnt; i++) tx[i] = 8'($urandom);
      rv.base    = ($urandom_range(0, 3) == 0) ? AW'(22'h3FFFFF - AW'($urandom_range(0, 3)))
                                               : AW'($urandom);
      rv.gap     = $urandom_range(0, 2);
      rv.corrupt = ($urandom_range(0, 3) == 0);
      rv.preload = 1'b0;
      rv.spam    = $urandom_range(0, 1) == 1;
      rv.exp_sum = model(rv.base, rv.cnt);
      rv.exp_err = rv.corrupt;
      apply(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
